// File: rtl/rle_dec_if.sv
// Handshake bundle between the run-length decoder and its input/output FIFOs.
// The slave side is the decoder; the master side is whatever owns the FIFOs.
interface rle_dec_if;
    logic        recv_ready;
    logic [23:0] in_data;
    logic        end_of_stream;
    logic        send_ready;
    logic        rd_req;
    logic        wr_req;
    logic [7:0]  out_data;
    logic        flush_done;

    modport slave (
        input  recv_ready, in_data, end_of_stream, send_ready,
        output rd_req, wr_req, out_data, flush_done
    );

    modport master (
        output recv_ready, in_data, end_of_stream, send_ready,
        input  rd_req, wr_req, out_data, flush_done
    );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit, 23-bit run} words into a bit stream packed
// LSB-first into bytes, with a zero-padded flush of the last partial byte.
module rle_dec (
    input  logic     clk,
    input  logic     rst,
    rle_dec_if.slave bus
);

    typedef enum logic [2:0] {
        INIT,
        REQUEST_INPUT,
        WAIT_INPUT,
        READ_INPUT,
        EMIT_BITS,
        WRITE_REQ,
        WAIT_OUTPUT,
        FLUSH_CHECK
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [7:0]  byte_buf;
    logic [7:0]  byte_buf_n;
    logic [2:0]  bit_pos;
    logic [2:0]  bit_pos_n;
    logic [22:0] run_cnt;
    logic [22:0] run_cnt_n;
    logic        bit_val;
    logic        bit_val_n;
    logic        flush_pend;
    logic        flush_pend_n;
    logic        rd_q;
    logic        rd_n;
    logic        wr_q;
    logic        wr_n;
    logic        done_q;
    logic        done_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        byte_buf_n   = byte_buf;
        bit_pos_n    = bit_pos;
        run_cnt_n    = run_cnt;
        bit_val_n    = bit_val;
        flush_pend_n = flush_pend;
        rd_n         = 1'b0;
        wr_n         = 1'b0;
        done_n       = 1'b0;

        case (state)
            INIT: begin
                byte_buf_n   = 8'h00;
                bit_pos_n    = 3'd0;
                run_cnt_n    = 23'd0;
                flush_pend_n = 1'b0;
                state_n      = REQUEST_INPUT;
            end
            REQUEST_INPUT: begin
                // Queued words always win over end_of_stream.
                if (bus.recv_ready) begin
                    rd_n    = 1'b1;
                    state_n = WAIT_INPUT;
                end else if (bus.end_of_stream) begin
                    state_n = FLUSH_CHECK;
                end
            end
            WAIT_INPUT: begin
                state_n = READ_INPUT;
            end
            READ_INPUT: begin
                bit_val_n = bus.in_data[23];
                run_cnt_n = bus.in_data[22:0];
                state_n   = (bus.in_data[22:0] == 23'd0) ? REQUEST_INPUT : EMIT_BITS;
            end
            EMIT_BITS: begin
                byte_buf_n[bit_pos] = bit_val;
                run_cnt_n           = run_cnt - 23'd1;
                bit_pos_n           = bit_pos + 3'd1;
                // A full byte takes precedence; any leftover run resumes after the write.
                if (bit_pos == 3'd7) begin
                    state_n = WRITE_REQ;
                end else if (run_cnt == 23'd1) begin
                    state_n = REQUEST_INPUT;
                end
            end
            WRITE_REQ: begin
                if (bus.send_ready) begin
                    wr_n    = 1'b1;
                    state_n = WAIT_OUTPUT;
                end
            end
            WAIT_OUTPUT: begin
                byte_buf_n = 8'h00;
                bit_pos_n  = 3'd0;
                if (run_cnt != 23'd0) begin
                    state_n = EMIT_BITS;
                end else if (flush_pend) begin
                    done_n  = 1'b1;
                    state_n = INIT;
                end else begin
                    state_n = REQUEST_INPUT;
                end
            end
            FLUSH_CHECK: begin
                if (bit_pos != 3'd0) begin
                    flush_pend_n = 1'b1;
                    state_n      = WRITE_REQ;
                end else begin
                    done_n  = 1'b1;
                    state_n = INIT;
                end
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_buf   <= 8'h00;
            bit_pos    <= 3'd0;
            run_cnt    <= 23'd0;
            bit_val    <= 1'b0;
            flush_pend <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            byte_buf   <= byte_buf_n;
            bit_pos    <= bit_pos_n;
            run_cnt    <= run_cnt_n;
            bit_val    <= bit_val_n;
            flush_pend <= flush_pend_n;
            rd_q       <= rd_n;
            wr_q       <= wr_n;
            done_q     <= done_n;
        end
    end

    assign bus.rd_req     = rd_q;
    assign bus.wr_req     = wr_q;
    assign bus.out_data   = byte_buf;
    assign bus.flush_done = done_q;

endmodule
